// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stage
package fetch_pkg;

   localparam int          FETCH_W          = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [FETCH_W-1:0] pc;
      logic [FETCH_W-1:0] instr;
      logic [FETCH_W-1:0] pc_plus4;
   } fetch_pkt_t;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - small FIFO of fetch packets between fetch and decode
module fetch_buf
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  fetch_pkt_t             push_pkt_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output fetch_pkt_t             head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);

   fetch_pkt_t    mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A full buffer may still accept a push when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o && !flush_i;
   assign do_push = push_i && (!full_o || do_pop) && !flush_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_pkt_i;
   end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch sequencer: PC, redirect arbitration, halt and decode handoff
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH = FETCH_W,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int                    BUF_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redir_valid,
   input  logic [DATA_WIDTH-1:0] redir_target,
   input  logic                  trap_valid,
   input  logic [DATA_WIDTH-1:0] trap_target,
   input  logic                  halt,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  dec_valid,
   input  logic                  dec_ready,
   output logic [DATA_WIDTH-1:0] dec_pc,
   output logic [DATA_WIDTH-1:0] dec_instr,
   output logic [DATA_WIDTH-1:0] dec_pc_plus4,
   output logic [DATA_WIDTH-1:0] pc,
   output logic [31:0]           fetch_count
);

   localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

   fetch_state_t          state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d, pc_plus4;
   logic [31:0]           fcount_q, fcount_d;

   logic                  push, flush, handshake, fire;
   fetch_pkt_t            push_pkt, head_pkt;
   logic                  buf_full, buf_empty;
   logic [$clog2(BUF_DEPTH):0] buf_count;

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign fetch_count = fcount_q;
   assign pc_plus4  = pc_q + DATA_WIDTH'(4);
   assign push_pkt  = '{pc: pc_q, instr: imem_rdata, pc_plus4: pc_plus4};

   assign dec_valid    = (buf_count != '0);
   assign handshake    = dec_valid && dec_ready;
   assign fire         = !buf_full || handshake;
   assign dec_pc       = buf_empty ? '0 : head_pkt.pc;
   assign dec_instr    = buf_empty ? '0 : head_pkt.instr;
   assign dec_pc_plus4 = buf_empty ? '0 : head_pkt.pc_plus4;

   // Priority: trap > branch/jump > halt > sequential advance.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      fcount_d = fcount_q;
      push     = 1'b0;
      flush    = 1'b0;
      if (trap_valid) begin
         flush   = 1'b1;
         pc_d    = trap_target & ALIGN_MASK;
         state_d = RUN;
      end else if (redir_valid) begin
         flush   = 1'b1;
         pc_d    = redir_target & ALIGN_MASK;
         state_d = (state_q == HALT) ? HALT : RUN;
      end else begin
         case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
               if (halt) begin
                  state_d = HALT;
               end else if (fire) begin
                  push     = 1'b1;
                  pc_d     = pc_plus4;
                  fcount_d = fcount_q + 32'd1;
               end
            end
            HALT:    state_d = HALT;
            default: state_d = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= BOOT;
         pc_q     <= RESET_PC;
         fcount_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         fcount_q <= fcount_d;
      end
   end

   fetch_buf #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_pkt_i (push_pkt),
      .pop_i      (handshake),
      .flush_i    (flush),
      .head_o     (head_pkt),
      .full_o     (buf_full),
      .empty_o    (buf_empty),
      .count_o    (buf_count)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        redir_valid, trap_valid, halt, dec_ready, dec_valid;
   logic [31:0] redir_target, trap_target, imem_addr, imem_rdata;
   logic [31:0] dec_pc, dec_instr, dec_pc_plus4, pc, fetch_count;

   int cmp_cnt = 0;
   int bad_cnt = 0;

   always #5 clk = ~clk;

   // Instruction memory image: word at address a is a ^ 0x13579BDF.
   assign imem_rdata = imem_addr ^ 32'h1357_9BDF;

   fetch_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .redir_valid  (redir_valid),
      .redir_target (redir_target),
      .trap_valid   (trap_valid),
      .trap_target  (trap_target),
      .halt         (halt),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .dec_valid    (dec_valid),
      .dec_ready    (dec_ready),
      .dec_pc       (dec_pc),
      .dec_instr    (dec_instr),
      .dec_pc_plus4 (dec_pc_plus4),
      .pc           (pc),
      .fetch_count  (fetch_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         bad_cnt++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; redir_valid = 1'b0; trap_valid = 1'b0; halt = 1'b0;
      redir_target = '0; trap_target = '0; dec_ready = 1'b1;
      #3;
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", {31'b0, dec_valid}, 32'h0);
      chk("rst_dec_pc", dec_pc, 32'h0);
      chk("rst_count", fetch_count, 32'h0);
      step(1);
      rst = 1'b1;

      step(1);
      chk("boot_valid", {31'b0, dec_valid}, 32'h0);
      chk("boot_pc", pc, 32'h0);
      step(1);
      chk("seq0_pc", dec_pc, 32'h0);
      chk("seq0_instr", dec_instr, 32'h1357_9BDF);
      step(1);
      chk("seq1_pc", dec_pc, 32'h4);
      chk("seq1_instr", dec_instr, 32'h1357_9BDB);
      step(1);
      chk("seq2_pc", dec_pc, 32'h8);
      chk("seq2_plus4", dec_pc_plus4, 32'hC);
      chk("seq_count", fetch_count, 32'd3);

      rst = 1'b0;
      #2;
      rst = 1'b1;
      dec_ready = 1'b0;
      step(2);
      chk("bp_first", dec_pc, 32'h0);
      step(4);
      chk("bp_hold_pc", dec_pc, 32'h0);
      chk("bp_hold_valid", {31'b0, dec_valid}, 32'h1);
      chk("bp_fetch_pc", pc, 32'h8);
      chk("bp_count", fetch_count, 32'd2);
      dec_ready = 1'b1;
      step(1);
      chk("bp_rel1", dec_pc, 32'h4);
      step(1);
      chk("bp_rel2", dec_pc, 32'h8);
      chk("bp_rel_pc", pc, 32'h10);

      dec_ready = 1'b0;
      redir_valid = 1'b1; redir_target = 32'h0000_0103;
      step(1);
      chk("br_valid", {31'b0, dec_valid}, 32'h0);
      chk("br_pc", pc, 32'h100);
      redir_valid = 1'b0; dec_ready = 1'b1;
      step(1);
      chk("br_dec_pc", dec_pc, 32'h100);
      chk("br_instr", dec_instr, 32'h1357_9ADF);

      trap_valid = 1'b1; trap_target = 32'h80;
      redir_valid = 1'b1; redir_target = 32'h100;
      step(1);
      chk("prio_pc", pc, 32'h80);
      chk("prio_valid", {31'b0, dec_valid}, 32'h0);
      trap_valid = 1'b0; redir_valid = 1'b0;
      step(1);
      chk("prio_dec_pc", dec_pc, 32'h80);

      redir_valid = 1'b1; redir_target = 32'h8;
      step(1);
      redir_valid = 1'b0;
      step(2);
      chk("pre_halt_dec", dec_pc, 32'hC);
      chk("pre_halt_pc", pc, 32'h10);
      halt = 1'b1;
      step(1);
      chk("halt_valid", {31'b0, dec_valid}, 32'h0);
      chk("halt_pc", pc, 32'h10);
      step(2);
      chk("halt_pc_hold", pc, 32'h10);
      chk("halt_count", fetch_count, 32'd8);
      redir_valid = 1'b1; redir_target = 32'h40;
      step(1);
      redir_valid = 1'b0;
      step(1);
      chk("halt_redir_pc", pc, 32'h40);
      chk("halt_redir_valid", {31'b0, dec_valid}, 32'h0);
      chk("halt_redir_count", fetch_count, 32'd8);
      halt = 1'b0;
      trap_valid = 1'b1; trap_target = 32'h200;
      step(1);
      trap_valid = 1'b0;
      chk("trap_pc", pc, 32'h200);
      step(1);
      chk("trap_dec_pc", dec_pc, 32'h200);
      chk("trap_count", fetch_count, 32'd9);

      trap_valid = 1'b1; trap_target = 32'hFFFF_FFFC;
      step(1);
      trap_valid = 1'b0;
      chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
      step(1);
      chk("wrap_dec_pc", dec_pc, 32'hFFFF_FFFC);
      chk("wrap_plus4", dec_pc_plus4, 32'h0);
      chk("wrap_pc", pc, 32'h0);
      step(1);
      chk("wrap_next", dec_pc, 32'h0);
      chk("wrap_pc4", pc, 32'h4);

      #3;
      rst = 1'b0;
      #1;
      chk("arst_pc", pc, 32'h0);
      chk("arst_valid", {31'b0, dec_valid}, 32'h0);
      chk("arst_count", fetch_count, 32'h0);
      chk("arst_dec_pc", dec_pc, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
      $finish;
   end

endmodule
